reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back controller for the multiple-cycle pipeline. It accepts a completed instruction from the EX/MEM boundary and, for loads, waits for the data memory's multi-cycle read to finish. It then drives the register file write port (`regWrite`/`writeReg`/`writeData`), which the register file samples on the falling clock edge. It stalls upstream stages while a load is outstanding, counts retired instructions, and flags memory reads that time out.

## Interface
- `DATA_W`, 32, datapath width
- `REG_ADDR_W`, 5, register index width
- `TIMEOUT_CYCLES`, 16, maximum cycles spent in WAIT_MEM before abort (≥2)
- `CNT_W`, 32, retire counter width
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `exmem_valid`  in  1  EX/MEM holds an instruction this cycle
- `exmem_reg_write`  in  1  instruction writes a register
- `exmem_mem_to_reg`  in  1  result comes from data memory (load)
- `exmem_reg_des`  in  REG_ADDR_W  destination register
- `exmem_alu_result`  in  DATA_W  ALU result
- `mem_ready`  in  1  data memory read data valid this cycle
- `mem_read_data`  in  DATA_W  data memory read data
- `wb_stall`  out  1  combinational; upstream holds EX/MEM and earlier stages
- `regWrite`  out  1  registered register-file write enable
- `writeReg`  out  REG_ADDR_W  registered write index
- `writeData`  out  DATA_W  registered write data
- `retire_count`  out  CNT_W  committed-instruction count
- `mem_error`  out  1  sticky load-timeout flag

## Operation
- States: IDLE and WAIT_MEM. A 2-bit encoding is permitted for future states.
- In IDLE with `exmem_valid`=1:
  - Non-load (`exmem_mem_to_reg`=0), or load with `mem_ready`=1: commit this cycle. Data is ALU result or `mem_read_data` respectively. Stay in IDLE.
  - Load with `mem_ready`=0: capture `exmem_reg_write` and `exmem_reg_des` into pending registers, clear the timeout counter, and go to WAIT_MEM.
- In WAIT_MEM, EX/MEM inputs other than `mem_ready`/`mem_read_data` are ignored; pending fields are used.
  - `mem_ready`=1: commit with `mem_read_data` and return to IDLE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES-1 without `mem_ready`: no commit, no retire, set `mem_error`, return to IDLE.
- Commit, effective on the next rising edge:
  - `regWrite` = reg_write && des≠0; `writeReg` = des; `writeData` = selected data.
  - `retire_count` += 1, regardless of reg_write.
- No commit: `regWrite`=0. `writeReg`/`writeData` hold their last values.
- Writes to register 0 are always suppressed.
- `retire_count` wraps from 2^CNT_W−1 to 0 without a flag.
- `mem_error` stays high until `reset`.
- `wb_stall` = (IDLE && exmem_valid && exmem_mem_to_reg && !mem_ready) || (WAIT_MEM && !mem_ready && timeout not reached).
- Reset, asynchronous at any point including mid-WAIT_MEM: state=IDLE, `regWrite`=0, `writeReg`=0, `writeData`=0, `retire_count`=0, `mem_error`=0, pending fields=0. `wb_stall` drops as soon as reset is asserted.

## Timing
- Non-load latency: EX/MEM valid in cycle N → `regWrite` high during cycle N+1. The register file writes on the falling edge within N+1.
- Load with `mem_ready` in cycle N+k (k≥0) → `regWrite` high during cycle N+k+1.
- `wb_stall` is high for exactly k cycles.
- `regWrite` is high for exactly one cycle per committing instruction. Back-to-back non-loads give consecutive single-cycle pulses.
- In WAIT_MEM, `mem_ready` arriving in the same cycle the timeout would fire takes priority: commit, no error.
- The timeout aborts after exactly TIMEOUT_CYCLES cycles in WAIT_MEM. `wb_stall` is low in the abort cycle.
- Upstream must keep EX/MEM stable while `wb_stall`=1. The block does not rely on this in WAIT_MEM.

## Structure
- Shared pipeline package holds:
  - the state enum (WB_IDLE, WB_WAIT_MEM)
  - `DATA_W` and `REG_ADDR_W` defaults
  - the zero-register constant, shared with the register file and forwarding logic
- Single module, no sub-modules. The timeout counter is a local `$clog2(TIMEOUT_CYCLES)`-bit register.

## Test plan
- Reset → all outputs 0. Non-load des=5, alu=0x1234 → next cycle `regWrite`=1, `writeReg`=5, `writeData`=0x1234, `retire_count`=1.
- Load des=7, `mem_ready` after 3 cycles with data 0xDEADBEEF → `wb_stall` high 3 cycles, then `regWrite` pulse with 7/0xDEADBEEF, `retire_count`+1.
- Non-load des=0, alu=0xFFFF → `regWrite` stays 0, `retire_count`+1. Store-like (reg_write=0) behaves the same.
- Load, `mem_ready` never asserted (TIMEOUT_CYCLES=16) → 16 cycles in WAIT_MEM, no `regWrite`, `mem_error`=1 and remains 1, count unchanged. The next non-load still commits.
- Reset asserted mid-WAIT_MEM, then released → IDLE, `wb_stall`=0, `retire_count`=0, no write from the aborted load.
- Preload `retire_count`=0xFFFFFFFF via 2^32−1 commits (or a forced value), one commit → 0. Back-to-back non-loads des=1,2,3 → three consecutive `regWrite` pulses.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared pipeline definitions: write-back state encoding, default datapath widths
// and the hard-wired zero register index used by register file and forwarding.
package reg_writeback_pkg;

    localparam int WB_DATA_W     = 32;
    localparam int WB_REG_ADDR_W = 5;

    localparam logic [WB_REG_ADDR_W-1:0] WB_ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1
    } wb_state_e;

endpackage

// File: rtl/reg_writeback_if.sv
// EX/MEM, data-memory and register-file-port bundle of the write-back stage.
// master = upstream pipeline / memory side, slave = the write-back controller.
interface reg_writeback_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  exmem_valid;
    logic                  exmem_reg_write;
    logic                  exmem_mem_to_reg;
    logic [REG_ADDR_W-1:0] exmem_reg_des;
    logic [DATA_W-1:0]     exmem_alu_result;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_read_data;
    logic                  wb_stall;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0]     writeData;
    logic [CNT_W-1:0]      retire_count;
    logic                  mem_error;

    modport master (
        output exmem_valid, exmem_reg_write, exmem_mem_to_reg, exmem_reg_des,
               exmem_alu_result, mem_ready, mem_read_data,
        input  wb_stall, regWrite, writeReg, writeData, retire_count, mem_error
    );

    modport slave (
        input  exmem_valid, exmem_reg_write, exmem_mem_to_reg, exmem_reg_des,
               exmem_alu_result, mem_ready, mem_read_data,
        output wb_stall, regWrite, writeReg, writeData, retire_count, mem_error
    );

endinterface

// File: rtl/reg_writeback.sv
// Write-back controller: commits EX/MEM results to the register file write port,
// holding the pipeline while a multi-cycle load is outstanding and aborting on timeout.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DATA_W         = WB_DATA_W,
    parameter int REG_ADDR_W     = WB_REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic           clock,
    input  logic           reset,
    reg_writeback_if.slave wb
);
    localparam int                    TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_DES = REG_ADDR_W'(WB_ZERO_REG);

    wb_state_e             state_r;
    wb_state_e             state_s;
    logic                  pend_we_r;
    logic [REG_ADDR_W-1:0] pend_des_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic                  reg_write_r;
    logic [REG_ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0]     write_data_r;
    logic [CNT_W-1:0]      retire_count_r;
    logic                  mem_error_r;

    logic                  commit_s;
    logic                  commit_we_s;
    logic [REG_ADDR_W-1:0] commit_des_s;
    logic [DATA_W-1:0]     commit_data_s;
    logic                  capture_s;
    logic                  abort_s;
    logic                  cnt_inc_s;
    logic                  stall_s;
    logic                  timeout_hit_s;

    assign timeout_hit_s = (to_cnt_r == TO_LAST);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= WB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: late data wins over a timeout firing in the same cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            WB_IDLE: begin
                if (wb.exmem_valid && wb.exmem_mem_to_reg && !wb.mem_ready) begin
                    state_s = WB_WAIT_MEM;
                end else begin
                    state_s = WB_IDLE;
                end
            end
            WB_WAIT_MEM: begin
                if (wb.mem_ready || timeout_hit_s) begin
                    state_s = WB_IDLE;
                end else begin
                    state_s = WB_WAIT_MEM;
                end
            end
            default: state_s = WB_IDLE;
        endcase
    end

    // Output/control decode: commit selection, pending capture, timeout and stall
    always_comb begin
        commit_s      = 1'b0;
        commit_we_s   = 1'b0;
        commit_des_s  = '0;
        commit_data_s = '0;
        capture_s     = 1'b0;
        abort_s       = 1'b0;
        cnt_inc_s     = 1'b0;
        stall_s       = 1'b0;
        case (state_r)
            WB_IDLE: begin
                if (wb.exmem_valid && (!wb.exmem_mem_to_reg || wb.mem_ready)) begin
                    commit_s      = 1'b1;
                    commit_we_s   = wb.exmem_reg_write && (wb.exmem_reg_des != ZERO_DES);
                    commit_des_s  = wb.exmem_reg_des;
                    commit_data_s = wb.exmem_mem_to_reg ? wb.mem_read_data : wb.exmem_alu_result;
                end else if (wb.exmem_valid) begin
                    capture_s = 1'b1;
                    stall_s   = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            WB_WAIT_MEM: begin
                if (wb.mem_ready) begin
                    commit_s      = 1'b1;
                    commit_we_s   = pend_we_r && (pend_des_r != ZERO_DES);
                    commit_des_s  = pend_des_r;
                    commit_data_s = wb.mem_read_data;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                    stall_s   = 1'b1;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // Pending load fields and WAIT_MEM timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_we_r  <= 1'b0;
            pend_des_r <= '0;
            to_cnt_r   <= '0;
        end else if (capture_s) begin
            pend_we_r  <= wb.exmem_reg_write;
            pend_des_r <= wb.exmem_reg_des;
            to_cnt_r   <= '0;
        end else if (cnt_inc_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Register-file write port, retire counter and sticky timeout flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_r    <= 1'b0;
            write_reg_r    <= '0;
            write_data_r   <= '0;
            retire_count_r <= '0;
            mem_error_r    <= 1'b0;
        end else begin
            reg_write_r <= commit_we_s;
            if (commit_s) begin
                write_reg_r    <= commit_des_s;
                write_data_r   <= commit_data_s;
                retire_count_r <= retire_count_r + CNT_W'(1);
            end
            if (abort_s) begin
                mem_error_r <= 1'b1;
            end
        end
    end

    // Stall is combinational but must vanish the moment reset is raised
    assign wb.wb_stall     = stall_s && !reset;
    assign wb.regWrite     = reg_write_r;
    assign wb.writeReg     = write_reg_r;
    assign wb.writeData    = write_data_r;
    assign wb.retire_count = retire_count_r;
    assign wb.mem_error    = mem_error_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random transactions
// checked against a transaction-level model (latency k, commit iff k <= timeout).
module tb_reg_writeback;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int TO  = 16;
    localparam int CW  = 32;
    localparam int CW2 = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [AW-1:0] exp_reg;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_count;
    logic          exp_err;

    reg_writeback_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW))  wb ();
    reg_writeback_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW2)) wb2 ();

    reg_writeback #(.DATA_W(DW), .REG_ADDR_W(AW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clock (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    reg_writeback #(.DATA_W(DW), .REG_ADDR_W(AW), .TIMEOUT_CYCLES(TO), .CNT_W(CW2)) dut_narrow (
        .clock (clk),
        .reset (reset),
        .wb    (wb2.slave)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_reg   = '0;
        exp_data  = '0;
        exp_count = '0;
        exp_err   = 1'b0;
    endtask

    task automatic idle_inputs();
        wb.exmem_valid      = 1'b0;
        wb.exmem_reg_write  = 1'b0;
        wb.exmem_mem_to_reg = 1'b0;
        wb.exmem_reg_des    = '0;
        wb.exmem_alu_result = '0;
        wb.mem_ready        = 1'b0;
        wb.mem_read_data    = '0;
    endtask

    // One instruction: load data arrives k cycles after issue; commits iff k <= TO.
    task automatic do_txn(input bit is_load, input bit we, input logic [AW-1:0] des,
                          input logic [DW-1:0] alu, input logic [DW-1:0] mdata,
                          input int k, input string tag);
        int  last;
        int  stalls;
        int  exp_stalls;
        bit  commits;
        bit  exp_we;
        last       = !is_load ? 0 : ((k <= TO) ? k : TO);
        commits    = !is_load || (k <= TO);
        exp_stalls = !is_load ? 0 : (commits ? k : TO);
        stalls     = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_checks++;
                if (wb.regWrite !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_regWrite cycle %0d: got %0b expected 0", tag, c, wb.regWrite);
                end
            end
            wb.exmem_valid      = 1'b1;
            wb.exmem_reg_write  = we;
            wb.exmem_mem_to_reg = is_load;
            wb.exmem_reg_des    = des;
            wb.exmem_alu_result = alu;
            wb.mem_ready        = is_load ? (c == k) : 1'($urandom_range(0, 1));
            wb.mem_read_data    = (is_load && c == k) ? mdata : $urandom;
            #1;
            if (wb.wb_stall === 1'b1) stalls++;
        end
        @(negedge clk);
        idle_inputs();
        exp_we = commits && we && (des != 5'd0);
        if (commits) begin
            exp_count = exp_count + 32'd1;
            exp_reg   = des;
            exp_data  = is_load ? mdata : alu;
        end else begin
            exp_err = 1'b1;
        end
        n_checks++;
        if (stalls != exp_stalls) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stalls);
        end
        n_checks++;
        if (wb.regWrite !== exp_we) begin
            n_fail++;
            $display("FAIL %s regWrite: got %0b expected %0b", tag, wb.regWrite, exp_we);
        end
        n_checks++;
        if (wb.writeReg !== exp_reg) begin
            n_fail++;
            $display("FAIL %s writeReg: got %0d expected %0d", tag, wb.writeReg, exp_reg);
        end
        n_checks++;
        if (wb.writeData !== exp_data) begin
            n_fail++;
            $display("FAIL %s writeData: got %h expected %h", tag, wb.writeData, exp_data);
        end
        n_checks++;
        if (wb.retire_count !== exp_count) begin
            n_fail++;
            $display("FAIL %s retire_count: got %0d expected %0d", tag, wb.retire_count, exp_count);
        end
        n_checks++;
        if (wb.mem_error !== exp_err) begin
            n_fail++;
            $display("FAIL %s mem_error: got %0b expected %0b", tag, wb.mem_error, exp_err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        wb2.exmem_valid = 1'b0; wb2.exmem_reg_write = 1'b0; wb2.exmem_mem_to_reg = 1'b0;
        wb2.exmem_reg_des = '0; wb2.exmem_alu_result = '0; wb2.mem_ready = 1'b0; wb2.mem_read_data = '0;
        reset = 1'b1;
        model_reset();
        // pending-load inputs while reset is held must not raise the stall
        wb.exmem_valid = 1'b1; wb.exmem_mem_to_reg = 1'b1; wb.exmem_reg_write = 1'b1;
        #22;
        n_checks++;
        if (wb.wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset wb_stall: got %0b expected 0", wb.wb_stall); end
        n_checks++;
        if (wb.regWrite !== 1'b0) begin n_fail++; $display("FAIL reset regWrite: got %0b expected 0", wb.regWrite); end
        n_checks++;
        if (wb.writeReg !== exp_reg) begin n_fail++; $display("FAIL reset writeReg: got %0d expected 0", wb.writeReg); end
        n_checks++;
        if (wb.writeData !== exp_data) begin n_fail++; $display("FAIL reset writeData: got %h expected 0", wb.writeData); end
        n_checks++;
        if (wb.retire_count !== exp_count) begin n_fail++; $display("FAIL reset retire_count: got %0d expected 0", wb.retire_count); end
        n_checks++;
        if (wb.mem_error !== exp_err) begin n_fail++; $display("FAIL reset mem_error: got %0b expected 0", wb.mem_error); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        int model_cnt;
        model_cnt = 0;
        @(negedge clk);
        wb2.exmem_valid = 1'b1; wb2.exmem_reg_write = 1'b1; wb2.exmem_reg_des = 5'd4;
        wb2.exmem_alu_result = 32'h0000_00AA;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            model_cnt = (model_cnt + 1) % (1 << CW2);
            if (i >= 14) begin
                n_checks++;
                if (int'(wb2.retire_count) != model_cnt) begin
                    n_fail++;
                    $display("FAIL wrap retire_count after %0d commits: got %0d expected %0d", i + 1, wb2.retire_count, model_cnt);
                end
            end
        end
        wb2.exmem_valid = 1'b0;
    endtask

    task automatic test_non_load();
        do_txn(1'b0, 1'b1, 5'd5, 32'h0000_1234, $urandom, 0, "nonload");
        @(negedge clk);
        n_checks++;
        if (wb.regWrite !== 1'b0) begin n_fail++; $display("FAIL nonload_pulse regWrite: got %0b expected 0", wb.regWrite); end
    endtask

    task automatic test_load_wait();
        do_txn(1'b1, 1'b1, 5'd7, $urandom, 32'hDEAD_BEEF, 3, "load_k3");
        do_txn(1'b1, 1'b1, 5'd11, $urandom, 32'h0BAD_F00D, 0, "load_k0");
    endtask

    task automatic test_zero_reg();
        do_txn(1'b0, 1'b1, 5'd0, 32'h0000_FFFF, $urandom, 0, "zero_des");
        do_txn(1'b0, 1'b0, 5'd9, 32'h1357_9BDF, $urandom, 0, "store_like");
        do_txn(1'b1, 1'b0, 5'd4, $urandom, 32'h2468_ACE0, 2, "load_nowe");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [4];
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (wb.regWrite !== 1'b1 || wb.writeReg !== AW'(i) || wb.writeData !== d[i]) begin
                    n_fail++;
                    $display("FAIL b2b pulse %0d: got we=%0b reg=%0d data=%h expected we=1 reg=%0d data=%h",
                             i, wb.regWrite, wb.writeReg, wb.writeData, i, d[i]);
                end
            end
            if (i < 3) begin
                d[i+1] = $urandom;
                wb.exmem_valid = 1'b1; wb.exmem_reg_write = 1'b1; wb.exmem_mem_to_reg = 1'b0;
                wb.exmem_reg_des = AW'(i + 1); wb.exmem_alu_result = d[i+1];
            end else begin
                idle_inputs();
            end
        end
        exp_count = exp_count + 32'd3;
        exp_reg   = 5'd3;
        exp_data  = d[3];
        @(negedge clk);
        n_checks++;
        if (wb.regWrite !== 1'b0) begin n_fail++; $display("FAIL b2b tail regWrite: got %0b expected 0", wb.regWrite); end
        n_checks++;
        if (wb.retire_count !== exp_count) begin n_fail++; $display("FAIL b2b retire_count: got %0d expected %0d", wb.retire_count, exp_count); end
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 1'b1, 5'd12, $urandom, $urandom, 1000, "timeout");
        do_txn(1'b0, 1'b1, 5'd3, 32'h0000_0033, $urandom, 0, "after_timeout");
        do_txn(1'b1, 1'b1, 5'd13, $urandom, 32'hCAFE_0016, TO, "ready_at_limit");
        do_txn(1'b1, 1'b1, 5'd14, $urandom, 32'hCAFE_0017, TO + 1, "ready_past_limit");
        do_txn(1'b1, 1'b1, 5'd15, $urandom, 32'hCAFE_000F, TO - 1, "ready_before_limit");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        wb.exmem_valid = 1'b1; wb.exmem_reg_write = 1'b1; wb.exmem_mem_to_reg = 1'b1;
        wb.exmem_reg_des = 5'd9; wb.mem_ready = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (wb.wb_stall !== 1'b0) begin n_fail++; $display("FAIL midreset wb_stall: got %0b expected 0", wb.wb_stall); end
        n_checks++;
        if (wb.retire_count !== exp_count || wb.mem_error !== exp_err || wb.writeReg !== exp_reg || wb.writeData !== exp_data) begin
            n_fail++;
            $display("FAIL midreset outputs: got cnt=%0d err=%0b reg=%0d data=%h expected all 0",
                     wb.retire_count, wb.mem_error, wb.writeReg, wb.writeData);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        wb.mem_ready = 1'b1; wb.mem_read_data = $urandom;
        #1;
        n_checks++;
        if (wb.wb_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_after wb_stall: got %0b expected 0", wb.wb_stall); end
        @(negedge clk);
        wb.mem_ready = 1'b0;
        n_checks++;
        if (wb.regWrite !== 1'b0 || wb.retire_count !== exp_count) begin
            n_fail++;
            $display("FAIL midreset_after write: got we=%0b cnt=%0d expected we=0 cnt=0", wb.regWrite, wb.retire_count);
        end
    endtask

    task automatic test_random();
        int r;
        int k;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            k = (r < 7) ? r : ((r == 7) ? TO : ((r == 8) ? TO + 1 : TO + 4));
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                   $urandom, $urandom, k, "random");
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_non_load();
        test_load_wait();
        test_zero_reg();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
